// File: rtl/uart_boot_loader.sv
// Boot-time serial loader: reads LOAD/GO frames from the uart receive buffer,
// writes payload words to memory and answers every frame with one reply byte.
module uart_boot_loader #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic [7:0]  uart_do,
  output logic        uart_re,
  output logic        uart_we,
  output logic [7:0]  uart_di,
  input  logic        uart_wait,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  output logic        busy,
  output logic        boot_done,
  output logic [31:0] boot_addr
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_L_ADDR = 4'd1;
  localparam logic [3:0] S_L_CNT  = 4'd2;
  localparam logic [3:0] S_L_DATA = 4'd3;
  localparam logic [3:0] S_L_WR   = 4'd4;
  localparam logic [3:0] S_L_CHK  = 4'd5;
  localparam logic [3:0] S_G_ADDR = 4'd6;
  localparam logic [3:0] S_REPLY  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [1:0] RD_LOOK = 2'd0;
  localparam logic [1:0] RD_TAKE = 2'd1;
  localparam logic [1:0] RD_DEAD = 2'd2;

  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_G = 8'h47;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_Q = 8'h3F;

  logic [3:0]  state_r, state_s;
  logic [1:0]  rd_ph_r, rd_ph_s;
  logic [1:0]  idx_r, idx_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] word_r, word_s;
  logic [15:0] cnt_r, cnt_s;
  logic [7:0]  chk_r, chk_s;
  logic        go_r, go_s;
  logic        want_byte_s, got_byte_s;
  logic        re_s, we_s, mv_s, bd_s, busy_s;
  logic [7:0]  di_s;
  logic [31:0] ma_s, md_s, ba_s;
  logic [3:0]  ws_s;

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    addr_s  = addr_r;
    word_s  = word_r;
    cnt_s   = cnt_r;
    chk_s   = chk_r;
    go_s    = go_r;
    re_s    = 1'b0;
    we_s    = uart_we;
    di_s    = uart_di;
    mv_s    = mem_valid;
    ma_s    = mem_addr;
    md_s    = mem_wdata;
    ws_s    = mem_wstrb;
    bd_s    = boot_done;
    ba_s    = boot_addr;
    got_byte_s = (rd_ph_r == RD_TAKE);

    case (state_r)
      S_IDLE, S_L_ADDR, S_L_CNT, S_L_DATA, S_L_CHK, S_G_ADDR: want_byte_s = 1'b1;
      default: want_byte_s = 1'b0;
    endcase

    // One strobe cycle captures the byte, the next is dead while uart_valid falls.
    if (rd_ph_r == RD_TAKE) begin
      rd_ph_s = RD_DEAD;
    end else if ((rd_ph_r == RD_LOOK) && want_byte_s && uart_valid) begin
      rd_ph_s = RD_TAKE;
      re_s    = 1'b1;
    end else begin
      rd_ph_s = RD_LOOK;
    end

    case (state_r)
      S_IDLE: begin
        if (got_byte_s) begin
          idx_s = 2'd0;
          if (uart_do == CH_L) begin
            state_s = S_L_ADDR;
          end else if (uart_do == CH_G) begin
            state_s = S_G_ADDR;
          end else begin
            we_s    = 1'b1;
            di_s    = CH_Q;
            go_s    = 1'b0;
            state_s = S_REPLY;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_L_ADDR: begin
        if (got_byte_s) begin
          addr_s = {uart_do, addr_r[31:8]};
          idx_s  = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            addr_s[1:0] = 2'b00;
            state_s     = S_L_CNT;
          end else begin
            state_s = S_L_ADDR;
          end
        end else begin
          state_s = S_L_ADDR;
        end
      end
      S_L_CNT: begin
        if (got_byte_s) begin
          cnt_s = {uart_do, cnt_r[15:8]};
          idx_s = idx_r + 2'd1;
          if (idx_r == 2'd1) begin
            idx_s   = 2'd0;
            chk_s   = 8'h00;
            state_s = ({uart_do, cnt_r[15:8]} == 16'h0000) ? S_L_CHK : S_L_DATA;
          end else begin
            state_s = S_L_CNT;
          end
        end else begin
          state_s = S_L_CNT;
        end
      end
      S_L_DATA: begin
        if (got_byte_s) begin
          word_s = {uart_do, word_r[31:8]};
          chk_s  = chk_r + uart_do;
          idx_s  = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            mv_s    = 1'b1;
            ma_s    = addr_r;
            md_s    = {uart_do, word_r[31:8]};
            ws_s    = 4'hF;
            state_s = S_L_WR;
          end else begin
            state_s = S_L_DATA;
          end
        end else begin
          state_s = S_L_DATA;
        end
      end
      S_L_WR: begin
        if (mem_valid && mem_ready) begin
          mv_s    = 1'b0;
          ws_s    = 4'h0;
          addr_s  = addr_r + 32'd4;
          cnt_s   = cnt_r - 16'd1;
          state_s = (cnt_r == 16'd1) ? S_L_CHK : S_L_DATA;
        end else begin
          state_s = S_L_WR;
        end
      end
      S_L_CHK: begin
        if (got_byte_s) begin
          we_s    = 1'b1;
          di_s    = (uart_do == chk_r) ? CH_K : CH_E;
          go_s    = 1'b0;
          state_s = S_REPLY;
        end else begin
          state_s = S_L_CHK;
        end
      end
      S_G_ADDR: begin
        if (got_byte_s) begin
          addr_s = {uart_do, addr_r[31:8]};
          idx_s  = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            we_s    = 1'b1;
            di_s    = CH_K;
            go_s    = 1'b1;
            state_s = S_REPLY;
          end else begin
            state_s = S_G_ADDR;
          end
        end else begin
          state_s = S_G_ADDR;
        end
      end
      S_REPLY: begin
        // A GO only takes effect once its acknowledge has left.
        if (uart_we && !uart_wait) begin
          we_s = 1'b0;
          if (go_r) begin
            bd_s    = 1'b1;
            ba_s    = addr_r;
            state_s = S_DONE;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_REPLY;
        end
      end
      S_DONE: begin
        state_s = S_DONE;
        we_s    = 1'b0;
        mv_s    = 1'b0;
      end
      default: begin
        state_s = S_IDLE;
        we_s    = 1'b0;
        mv_s    = 1'b0;
        ws_s    = 4'h0;
      end
    endcase

    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      rd_ph_r   <= RD_LOOK;
      idx_r     <= 2'd0;
      addr_r    <= 32'h0000_0000;
      word_r    <= 32'h0000_0000;
      cnt_r     <= 16'h0000;
      chk_r     <= 8'h00;
      go_r      <= 1'b0;
      uart_re   <= 1'b0;
      uart_we   <= 1'b0;
      uart_di   <= 8'h00;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'h0;
      busy      <= 1'b0;
      boot_done <= 1'b0;
      boot_addr <= RESET_PC;
    end else begin
      state_r   <= state_s;
      rd_ph_r   <= rd_ph_s;
      idx_r     <= idx_s;
      addr_r    <= addr_s;
      word_r    <= word_s;
      cnt_r     <= cnt_s;
      chk_r     <= chk_s;
      go_r      <= go_s;
      uart_re   <= re_s;
      uart_we   <= we_s;
      uart_di   <= di_s;
      mem_valid <= mv_s;
      mem_addr  <= ma_s;
      mem_wdata <= md_s;
      mem_wstrb <= ws_s;
      busy      <= busy_s;
      boot_done <= bd_s;
      boot_addr <= ba_s;
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: frames are fed byte by byte, expected
// memory writes and replies are queued up front and matched as they appear.
module tb_uart_boot_loader;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        uart_valid;
  logic [7:0]  uart_do;
  logic        uart_re;
  logic        uart_we;
  logic [7:0]  uart_di;
  logic        uart_wait;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        busy;
  logic        boot_done;
  logic [31:0] boot_addr;

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int rep_cnt = 0;
  int wr_cnt = 0;
  int viol_cnt = 0;
  int unstable_cnt = 0;
  int mem_delay = 0;
  int wait_hold = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  exp_rep_q[$];

  uart_boot_loader #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .uart_valid(uart_valid), .uart_do(uart_do),
    .uart_re(uart_re), .uart_we(uart_we), .uart_di(uart_di), .uart_wait(uart_wait),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .busy(busy),
    .boot_done(boot_done), .boot_addr(boot_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and uart-transmitter responders with programmable stall lengths.
  task automatic responder();
    int mc = 0;
    int wc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_valid === 1'b1) begin
        mem_ready = (mc >= mem_delay);
        mc++;
      end else begin
        mem_ready = 1'b0;
        mc = 0;
      end
      if (uart_we === 1'b1) begin
        uart_wait = (wc < wait_hold);
        wc++;
      end else begin
        uart_wait = 1'b0;
        wc = 0;
      end
    end
  endtask

  // Scoreboard: compare each accepted write/reply against the expected queues.
  task automatic monitor();
    logic pv_m = 1'b0, pacc_m = 1'b0, pv_u = 1'b0, pacc_u = 1'b0, p_re = 1'b0;
    logic [31:0] pa = 32'h0, pd = 32'h0, ea, ed;
    logic [7:0]  pdi = 8'h0, er;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv_m = 1'b0;
        pv_u = 1'b0;
        p_re = 1'b0;
      end else begin
        if (uart_re) re_cnt++;
        if (uart_re && (mem_valid || uart_we || p_re)) viol_cnt++;
        if (!mem_valid && mem_wstrb !== 4'h0) viol_cnt++;
        if (mem_valid && pv_m && !pacc_m && (mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== 4'hF))
          unstable_cnt++;
        if (uart_we && pv_u && !pacc_u && uart_di !== pdi) unstable_cnt++;
        if (mem_valid && mem_ready) begin
          wr_cnt++;
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL mem_write unexpected addr=%h data=%h expected none", mem_addr, mem_wdata);
          end else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (mem_addr !== ea || mem_wdata !== ed || mem_wstrb !== 4'hF) begin
              errors++;
              $display("FAIL mem_write got addr=%h data=%h strb=%h exp addr=%h data=%h strb=f",
                       mem_addr, mem_wdata, mem_wstrb, ea, ed);
            end
          end
        end
        if (uart_we && !uart_wait) begin
          rep_cnt++;
          checks++;
          if (exp_rep_q.size() == 0) begin
            errors++;
            $display("FAIL reply unexpected byte=%h expected none", uart_di);
          end else begin
            er = exp_rep_q.pop_front();
            if (uart_di !== er) begin
              errors++;
              $display("FAIL reply got=%h exp=%h", uart_di, er);
            end
          end
        end
        pv_m = mem_valid; pacc_m = mem_valid && mem_ready; pa = mem_addr; pd = mem_wdata;
        pv_u = uart_we; pacc_u = uart_we && !uart_wait; pdi = uart_di; p_re = uart_re;
      end
    end
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    uart_valid = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_rep_q.delete();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(posedge clk);
    #1;
    uart_do = b;
    uart_valid = 1'b1;
    while (uart_re !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout byte=%h no uart_re within 400 cycles", b);
      uart_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      uart_valid = 1'b0;
    end
  endtask

  task automatic send_load(input logic [31:0] a, input int n, input logic [31:0] w0,
                           input logic [31:0] w1, input logic force_chk, input logic [7:0] chk_val);
    logic [7:0]  sum, chk;
    logic [31:0] w, wa;
    sum = 8'h00;
    wa = a & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int k = 0; k < 4; k++) sum = sum + w[8*k +: 8];
      exp_addr_q.push_back(wa + 32'(4 * i));
      exp_data_q.push_back(w);
    end
    chk = force_chk ? chk_val : sum;
    exp_rep_q.push_back((chk == sum) ? 8'h4B : 8'h45);
    send_byte(8'h4C);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL load_busy got=%b exp=1", busy);
    end
    for (int k = 0; k < 4; k++) send_byte(a[8*k +: 8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    send_byte(chk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_rep_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s drain pending writes=%0d replies=%0d exp=0", tag, exp_addr_q.size(), exp_rep_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset(3);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({uart_re, uart_we, mem_valid, busy, boot_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=00000", {uart_re, uart_we, mem_valid, busy, boot_done});
    end
    checks++;
    if ({uart_di, mem_addr, mem_wdata, mem_wstrb} !== 76'h0) begin
      errors++;
      $display("FAIL reset_data got di=%h addr=%h wdata=%h strb=%h exp all 0", uart_di, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if (boot_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_boot_addr got=%h exp=%h", boot_addr, RESET_PC);
    end
    checks++;
    if (re_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_re got=%0d exp=0", re_cnt);
    end
  endtask

  task automatic test_load_ok();
    int re0 = re_cnt, wr0 = wr_cnt, rep0 = rep_cnt;
    send_load(32'h0000_1000, 2, 32'h4433_2211, 32'h8877_6655, 1'b0, 8'h00);
    drain("load_ok");
    checks++;
    if (re_cnt - re0 !== 16) begin
      errors++;
      $display("FAIL load_ok_re_count got=%0d exp=16", re_cnt - re0);
    end
    checks++;
    if (wr_cnt - wr0 !== 2 || rep_cnt - rep0 !== 1) begin
      errors++;
      $display("FAIL load_ok_counts got writes=%0d replies=%0d exp 2 1", wr_cnt - wr0, rep_cnt - rep0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL load_ok_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_load_bad_chk();
    int wr0 = wr_cnt;
    send_load(32'h0000_1000, 2, 32'h4433_2211, 32'h8877_6655, 1'b1, 8'h00);
    drain("load_bad_chk");
    checks++;
    if (wr_cnt - wr0 !== 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_writes got=%0d busy=%b exp 2 0", wr_cnt - wr0, busy);
    end
  endtask

  task automatic test_stall();
    int rep0 = rep_cnt;
    mem_delay = 5;
    wait_hold = 20;
    send_load(32'h0000_0400, 2, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 8'h00);
    drain("stall");
    mem_delay = 0;
    wait_hold = 0;
    checks++;
    if (unstable_cnt !== 0) begin
      errors++;
      $display("FAIL stall_stability got=%0d unstable cycles exp=0", unstable_cnt);
    end
    checks++;
    if (viol_cnt !== 0) begin
      errors++;
      $display("FAIL stall_re_rules got=%0d violations exp=0", viol_cnt);
    end
    checks++;
    if (rep_cnt - rep0 !== 1) begin
      errors++;
      $display("FAIL stall_reply_once got=%0d exp=1", rep_cnt - rep0);
    end
  endtask

  task automatic test_wrap_and_zero();
    int wr0 = wr_cnt;
    int rep0;
    send_load(32'hFFFF_FFFE, 2, 32'hCAFE_F00D, 32'h0BAD_C0DE, 1'b0, 8'h00);
    drain("wrap");
    checks++;
    if (wr_cnt - wr0 !== 2) begin
      errors++;
      $display("FAIL wrap_writes got=%0d exp=2", wr_cnt - wr0);
    end
    wr0 = wr_cnt;
    rep0 = rep_cnt;
    send_load(32'h0000_2000, 0, 32'h0, 32'h0, 1'b1, 8'h00);
    drain("count0");
    checks++;
    if (wr_cnt - wr0 !== 0 || rep_cnt - rep0 !== 1) begin
      errors++;
      $display("FAIL count0 got writes=%0d replies=%0d exp 0 1", wr_cnt - wr0, rep_cnt - rep0);
    end
  endtask

  task automatic test_bad_byte();
    int rep0 = rep_cnt;
    exp_rep_q.push_back(8'h3F);
    send_byte(8'h5A);
    drain("bad_byte");
    checks++;
    if (rep_cnt - rep0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_byte got replies=%0d busy=%b exp 1 0", rep_cnt - rep0, busy);
    end
  endtask

  task automatic test_go();
    int n = 0;
    int re0;
    logic [7:0] go_bytes[5];
    go_bytes = '{8'h47, 8'h00, 8'h00, 8'h01, 8'h00};
    wait_hold = 6;
    exp_rep_q.push_back(8'h4B);
    for (int i = 0; i < 5; i++) send_byte(go_bytes[i]);
    checks++;
    if (boot_done !== 1'b0 || boot_addr !== RESET_PC) begin
      errors++;
      $display("FAIL go_early got done=%b addr=%h exp 0 %h", boot_done, boot_addr, RESET_PC);
    end
    while (boot_done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    wait_hold = 0;
    checks++;
    if (boot_done !== 1'b1 || boot_addr !== 32'h0001_0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL go_done got done=%b addr=%h busy=%b exp 1 00010000 0", boot_done, boot_addr, busy);
    end
    drain("go");
    re0 = re_cnt;
    uart_do = 8'h4C;
    uart_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (re_cnt !== re0 || uart_we !== 1'b0 || mem_valid !== 1'b0 || boot_done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignores got re=%0d we=%b mv=%b done=%b exp 0 0 0 1", re_cnt - re0, uart_we, mem_valid, boot_done);
    end
    uart_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int wr0, rep0;
    logic [7:0] part[7];
    apply_reset(2);
    part = '{8'h4C, 8'h00, 8'h30, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 7; i++) send_byte(part[i]);
    send_byte(8'hAA);
    send_byte(8'hBB);
    apply_reset(2);
    wr0 = wr_cnt;
    rep0 = rep_cnt;
    checks++;
    if ({uart_re, uart_we, mem_valid, busy, boot_done, mem_wstrb} !== 9'b0 || boot_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midreset_outputs got re=%b we=%b mv=%b busy=%b done=%b strb=%h baddr=%h exp zeros %h",
               uart_re, uart_we, mem_valid, busy, boot_done, mem_wstrb, boot_addr, RESET_PC);
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt !== wr0 || rep_cnt !== rep0) begin
      errors++;
      $display("FAIL midreset_quiet got writes=%0d replies=%0d exp 0 0", wr_cnt - wr0, rep_cnt - rep0);
    end
    send_load(32'h0000_3000, 2, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 8'h00);
    drain("after_reset");
    checks++;
    if (wr_cnt - wr0 !== 2 || rep_cnt - rep0 !== 1 || viol_cnt !== 0) begin
      errors++;
      $display("FAIL after_reset got writes=%0d replies=%0d viol=%0d exp 2 1 0", wr_cnt - wr0, rep_cnt - rep0, viol_cnt);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    uart_valid = 1'b0;
    uart_do = 8'h00;
    mem_ready = 1'b0;
    uart_wait = 1'b0;
    fork
      responder();
      monitor();
    join_none
    test_reset();
    test_load_ok();
    test_load_bad_chk();
    test_stall();
    test_wrap_and_zero();
    test_bad_byte();
    test_go();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Bus-side initiator for the uart register interface: polls the uart receive buffer, reads bytes and parses a small serial load protocol.
- Writes the payload into memory as 32-bit words over a valid/ready bus.
- Sends one-byte replies through the uart transmit path.
- Sits between the uart and the memory arbiter at boot. It asserts boot_done with a start address when commanded, then idles until reset.

Parameters:
- RESET_PC, 32'h0000_0000, reset value of boot_addr.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uart_valid  in  1  uart receive buffer holds an unread byte
- uart_do  in  8  uart receive data
- uart_re  out  1  read strobe; clears the uart receive buffer
- uart_we  out  1  transmit request
- uart_di  out  8  transmit data
- uart_wait  in  1  uart transmitter busy; write not accepted this cycle
- mem_valid  out  1  memory write request
- mem_addr  out  32  word address; bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 4'hF while mem_valid is high, else 0
- mem_ready  in  1  memory accepts the write
- busy  out  1  a frame is in progress (any state other than IDLE and DONE)
- boot_done  out  1  sticky; the loader has finished
- boot_addr  out  32  start address for the CPU

Behaviour:
- Reset values:
  - uart_re, uart_we, mem_valid, busy, boot_done are 0.
  - uart_di, mem_addr, mem_wdata, mem_wstrb are 0.
  - boot_addr = RESET_PC.
  - State = IDLE.
  - Reset mid-frame abandons the frame with no further memory writes or replies.
- Byte read:
  - In any state that expects a byte, if uart_valid=1, assert uart_re for exactly one cycle and capture uart_do in that same cycle.
  - The following cycle is a dead cycle with no sampling, because uart_valid is still falling.
  - uart_re is never asserted while mem_valid=1 or uart_we=1.
- Byte send:
  - Drive uart_we=1 and hold uart_di stable.
  - The write is accepted on the first cycle where uart_we=1 and uart_wait=0; uart_we drops the next cycle.
- Memory write:
  - mem_valid=1 with addr, wdata and wstrb stable until mem_ready=1 is sampled; mem_valid drops the next cycle.
  - Byte reception stalls while a write is pending, so memory must accept within one uart byte time.
- Frame formats (multi-byte fields are little-endian):
  - LOAD: 'L'(0x4C), addr[4], count[2] in words, data[4*count], chk[1].
  - GO: 'G'(0x47), addr[4].
- States:
  - IDLE: wait for a byte.
    - 0x4C → L_ADDR.
    - 0x47 → G_ADDR.
    - Anything else → reply '?'(0x3F), then return to IDLE.
  - L_ADDR: 4 bytes → addr reg, with bits [1:0] forced to 0.
  - L_CNT: 2 bytes → 16-bit count; the checksum accumulator is cleared. If count=0 go to L_CHK, else L_DATA.
  - L_DATA: 4 bytes assembled LSB-first into a word; each byte is added to an 8-bit checksum (mod 256).
    - After the 4th byte go to L_WR.
  - L_WR: perform the memory write at addr.
    - Then addr += 4 (32-bit wrap: 0xFFFF_FFFC → 0x0000_0000) and count -= 1.
    - count != 0 → L_DATA; count == 0 → L_CHK.
  - L_CHK: 1 byte.
    - Equal to the accumulator → reply 'K'(0x4B).
    - Otherwise → reply 'E'(0x45).
    - Words already written stay written. Return to IDLE.
  - G_ADDR: 4 bytes → addr.
    - Reply 'K'; after the reply is accepted, set boot_addr = addr and boot_done = 1, then go to DONE.
  - DONE: terminal until reset; uart_re, uart_we and mem_valid are held at 0.
- Replies are serialized: no byte is read while a reply is pending.
- Maximum frame is 65535 words; no other length limit. There is no inter-byte timeout.

Test Plan:
- Reset, then idle with uart_valid=0 → all outputs at reset values; boot_addr=RESET_PC; no strobes.
- LOAD: 4C 00 10 00 00 02 00, then 11 22 33 44 55 66 77 88, then chk 0x64 →
  - writes 0x44332211 @0x1000 and 0x88776655 @0x1004, wstrb=F;
  - reply 0x4B;
  - exactly one uart_re per byte.
- Same frame with chk 0x00 → both words written, reply 0x45, state back to IDLE.
- mem_ready delayed 5 cycles and uart_wait held 20 cycles → mem_valid and data stable throughout the stall; no uart_re during the stall; reply sent once after wait drops.
- Wrap and count=0:
  - LOAD at 0xFFFF_FFFE with count=2 → writes at 0xFFFF_FFFC and then 0x0000_0000.
  - LOAD with count=0 and chk 0x00 → no writes, reply 'K'.
- Bad byte 0x5A → reply 0x3F.
- GO: 47 00 00 01 00 → reply 'K', then boot_done=1 and boot_addr=0x0001_0000. Further uart_valid is ignored.
- Reset asserted mid-LOAD → outputs return to reset values and the next frame is parsed correctly.
